// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel holding registers,
// explicit or round-robin destination select and a saturating stall counter.

module demux4_chan #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);
    // A load wins over an ack so a simultaneous ack+load refills without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            dout <= din;
            vld  <= 1'b1;
        end else if (ack) begin
            vld  <= 1'b0;
        end
    end
endmodule

module demux4_reg #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Se1,
    input  logic             Mode,
    input  logic             InValid,
    input  logic [WIDTH-1:0] In,
    output logic             InReady,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [WIDTH-1:0] Out4,
    output logic             Valid1,
    output logic             Valid2,
    output logic             Valid3,
    output logic             Valid4,
    input  logic             Ack1,
    input  logic             Ack2,
    input  logic             Ack3,
    input  logic             Ack4,
    output logic [7:0]       DropCount
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]            ack;
    logic [NUM_LANES-1:0]            vld;
    logic [NUM_LANES-1:0]            load;
    logic [NUM_LANES-1:0][WIDTH-1:0] dout;
    logic [1:0]                      rr_ptr;
    logic [1:0]                      tgt;
    logic                            xfer;

    assign ack     = {Ack4, Ack3, Ack2, Ack1};
    assign tgt     = Mode ? rr_ptr : Se1;
    // Ready follows the target's occupancy only; a same-cycle ack frees the slot.
    assign InReady = ~vld[tgt] | ack[tgt];
    assign xfer    = InValid & InReady;

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_chan
            assign load[k] = xfer && (tgt == 2'(k));
            demux4_chan #(.WIDTH(WIDTH)) u_chan (
                .clk  (Clk),
                .rst  (Reset),
                .load (load[k]),
                .ack  (ack[k]),
                .din  (In),
                .dout (dout[k]),
                .vld  (vld[k])
            );
        end
    endgenerate

    assign {Out4, Out3, Out2, Out1}         = {dout[3], dout[2], dout[1], dout[0]};
    assign {Valid4, Valid3, Valid2, Valid1} = vld;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr    <= 2'b00;
            DropCount <= 8'd0;
        end else begin
            if (xfer && Mode)
                rr_ptr <= rr_ptr + 2'd1;
            if (InValid && !InReady && DropCount != 8'hFF)
                DropCount <= DropCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_demux4_reg.sv
// Directed bench for demux4_reg (WIDTH=8): select, round-robin, back-to-back,
// ack handling, stall counter saturation and asynchronous reset.

module tb_demux4_reg;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] Se1;
    logic       Mode;
    logic       InValid;
    logic [7:0] In;
    logic       InReady;
    logic [7:0] Out1, Out2, Out3, Out4;
    logic       Valid1, Valid2, Valid3, Valid4;
    logic       Ack1, Ack2, Ack3, Ack4;
    logic [7:0] DropCount;

    int vectors = 0;
    int errors  = 0;

    demux4_reg #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Se1(Se1), .Mode(Mode), .InValid(InValid),
        .In(In), .InReady(InReady),
        .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
        .Valid1(Valid1), .Valid2(Valid2), .Valid3(Valid3), .Valid4(Valid4),
        .Ack1(Ack1), .Ack2(Ack2), .Ack3(Ack3), .Ack4(Ack4),
        .DropCount(DropCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Se1 = 2'd0; Mode = 1'b0; InValid = 1'b1; In = 8'hEE;
        {Ack1, Ack2, Ack3, Ack4} = 4'b0;
        tick(); tick();
        vectors++;
        if ({Valid4, Valid3, Valid2, Valid1} !== 4'b0000) begin
            errors++; $display("FAIL reset_valid got %b want 0000", {Valid4, Valid3, Valid2, Valid1});
        end
        vectors++;
        if ({Out4, Out3, Out2, Out1} !== 32'h0) begin
            errors++; $display("FAIL reset_out got %h want 00000000", {Out4, Out3, Out2, Out1});
        end
        vectors++;
        if (DropCount !== 8'd0 || InReady !== 1'b1) begin
            errors++; $display("FAIL reset_cnt_rdy got cnt=%0d rdy=%b want cnt=0 rdy=1", DropCount, InReady);
        end
        InValid = 1'b0;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_mode0_select();
        Mode = 1'b0; Se1 = 2'b10; In = 8'hA5; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        vectors++;
        if (Out3 !== 8'hA5 || {Valid4, Valid3, Valid2, Valid1} !== 4'b0100) begin
            errors++; $display("FAIL mode0_ch3 got out3=%h v=%b want out3=a5 v=0100", Out3, {Valid4, Valid3, Valid2, Valid1});
        end
        Ack3 = 1'b1;
        tick();
        Ack3 = 1'b0;
        vectors++;
        if (Valid3 !== 1'b0 || Out3 !== 8'hA5) begin
            errors++; $display("FAIL ack_clear got v3=%b out3=%h want v3=0 out3=a5", Valid3, Out3);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] data [4];
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
        Mode = 1'b1; Se1 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            In = data[i]; InValid = 1'b1;
            #1;
            vectors++;
            if (InReady !== 1'b1) begin
                errors++; $display("FAIL rr_ready%0d got %b want 1", i, InReady);
            end
            tick();
        end
        InValid = 1'b0;
        vectors++;
        if ({Out4, Out3, Out2, Out1} !== 32'h44332211 || {Valid4, Valid3, Valid2, Valid1} !== 4'b1111) begin
            errors++; $display("FAIL rr_fill got %h v=%b want 44332211 v=1111", {Out4, Out3, Out2, Out1}, {Valid4, Valid3, Valid2, Valid1});
        end
        In = 8'h55; InValid = 1'b1;
        #1;
        vectors++;
        if (InReady !== 1'b0) begin
            errors++; $display("FAIL rr_fifth_stall got rdy=%b want 0", InReady);
        end
        tick();
        InValid = 1'b0;
        vectors++;
        if (DropCount !== 8'd1 || Out1 !== 8'h11) begin
            errors++; $display("FAIL rr_drop got cnt=%0d out1=%h want cnt=1 out1=11", DropCount, Out1);
        end
    endtask

    task automatic test_back_to_back();
        // pointer wrapped to ch1: ack+offer there refills with no bubble
        Mode = 1'b1; Ack1 = 1'b1; In = 8'h66; InValid = 1'b1;
        #1;
        vectors++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL b2b_rr_ready got %b want 1", InReady);
        end
        tick();
        Ack1 = 1'b0; InValid = 1'b0;
        vectors++;
        if (Out1 !== 8'h66 || Valid1 !== 1'b1) begin
            errors++; $display("FAIL b2b_rr_ch1 got out1=%h v1=%b want 66 1", Out1, Valid1);
        end
        // ch2: drain, load 01, then ack+load 02 in the same cycle
        Mode = 1'b0; Se1 = 2'b01; Ack2 = 1'b1;
        tick();
        Ack2 = 1'b0; In = 8'h01; InValid = 1'b1;
        tick();
        Ack2 = 1'b1; In = 8'h02;
        #1;
        vectors++;
        if (InReady !== 1'b1 || Out2 !== 8'h01) begin
            errors++; $display("FAIL b2b_ch2_ready got rdy=%b out2=%h want 1 01", InReady, Out2);
        end
        tick();
        Ack2 = 1'b0; InValid = 1'b0;
        vectors++;
        if (Out2 !== 8'h02 || Valid2 !== 1'b1) begin
            errors++; $display("FAIL b2b_ch2 got out2=%h v2=%b want 02 1", Out2, Valid2);
        end
    endtask

    task automatic test_acks();
        Ack4 = 1'b1;
        tick();
        vectors++;
        if (Valid4 !== 1'b0) begin
            errors++; $display("FAIL ack4_clear got %b want 0", Valid4);
        end
        tick();
        Ack4 = 1'b0;
        vectors++;
        if (Valid4 !== 1'b0 || Out4 !== 8'h44) begin
            errors++; $display("FAIL ack_empty got v4=%b out4=%h want 0 44", Valid4, Out4);
        end
        Ack1 = 1'b1; Ack3 = 1'b1;
        tick();
        Ack1 = 1'b0; Ack3 = 1'b0;
        vectors++;
        if ({Valid4, Valid3, Valid2, Valid1} !== 4'b0010 || Out1 !== 8'h66 || Out3 !== 8'h33) begin
            errors++; $display("FAIL multi_ack got v=%b out1=%h out3=%h want 0010 66 33", {Valid4, Valid3, Valid2, Valid1}, Out1, Out3);
        end
    endtask

    task automatic test_saturate();
        Mode = 1'b0; Se1 = 2'b01; In = 8'hCC; InValid = 1'b1;
        for (int i = 0; i < 253; i++) tick();
        vectors++;
        if (DropCount !== 8'd254) begin
            errors++; $display("FAIL drop_254 got %0d want 254", DropCount);
        end
        for (int i = 0; i < 47; i++) tick();
        vectors++;
        if (DropCount !== 8'd255 || Out2 !== 8'h02) begin
            errors++; $display("FAIL drop_sat got cnt=%0d out2=%h want 255 02", DropCount, Out2);
        end
        InValid = 1'b0;
    endtask

    task automatic test_async_reset();
        // pointer is 01 here; move it to 10 via a back-to-back on ch2
        Mode = 1'b1; Ack2 = 1'b1; In = 8'h77; InValid = 1'b1;
        tick();
        Ack2 = 1'b0; InValid = 1'b0;
        vectors++;
        if (Out2 !== 8'h77 || Valid2 !== 1'b1) begin
            errors++; $display("FAIL pre_reset got out2=%h v2=%b want 77 1", Out2, Valid2);
        end
        #1;
        Reset = 1'b1;
        #1;
        vectors++;
        if (Valid2 !== 1'b0 || Out2 !== 8'h00 || DropCount !== 8'd0) begin
            errors++; $display("FAIL async_reset got v2=%b out2=%h cnt=%0d want 0 00 0", Valid2, Out2, DropCount);
        end
        tick();
        Reset = 1'b0;
        In = 8'h99; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        vectors++;
        if (Out1 !== 8'h99 || {Valid4, Valid3, Valid2, Valid1} !== 4'b0001) begin
            errors++; $display("FAIL post_reset_rr got out1=%h v=%b want 99 0001", Out1, {Valid4, Valid3, Valid2, Valid1});
        end
    endtask

    initial begin
        test_reset();
        test_mode0_select();
        test_round_robin();
        test_back_to_back();
        test_acks();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/demux4_reg.md
DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 Parameter WIDTH, default 1, data width of In and each Outk.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high; clears all state immediately, independent of Clk.
REQ-004 Se1  input  2  explicit destination select in Mode 0: 00->ch1, 01->ch2, 10->ch3, 11->ch4.
REQ-005 Mode  input  1  0 = explicit select via Se1; 1 = round-robin via internal pointer RrPtr.
REQ-006 InValid  input  1  In carries a word to deliver this cycle.
REQ-007 In  input  WIDTH  input data word.
REQ-008 InReady  output  1  combinational; transfer occurs on a cycle with InValid=1 and InReady=1.
REQ-009 Out1..Out4  output  WIDTH each  per-channel holding registers.
REQ-010 Valid1..Valid4  output  1 each  per-channel full flag.
REQ-011 Ack1..Ack4  input  1 each  consumer of channel k takes Outk this cycle.
REQ-012 DropCount  output  8  saturating count of stalled offers.

Function
REQ-013 Target channel: Se1+1 when Mode=0; RrPtr+1 when Mode=1, evaluated combinationally each cycle.
REQ-014 Per-channel state: EMPTY (Validk=0) or FULL (Validk=1); no other states.
REQ-015 InReady=1 iff target channel is EMPTY, or FULL with Ackk=1 in the same cycle; InReady does not depend on InValid.
REQ-016 On transfer: target Outk <= In, Validk <= 1 at the next edge; latency one cycle from transfer to Validk/Outk visible.
REQ-017 Non-target channels are unaffected by a transfer; Outk holds its value until that channel's next transfer.
REQ-018 FULL with Ackk=1 and no transfer to k: Validk <= 0; Outk unchanged.
REQ-019 FULL with Ackk=1 and transfer to k in the same cycle: Outk <= In, Validk stays 1 (back-to-back, no bubble).
REQ-020 Ackk while EMPTY: ignored; no state change.
REQ-021 Acks on several channels in one cycle are all honoured independently.
REQ-022 RrPtr: 2-bit register; increments by 1 on each transfer while Mode=1; wraps 11->00; unchanged on stall and while Mode=0.
REQ-023 Changing Mode does not alter RrPtr, Validk or Outk; new Mode takes effect the same cycle for target selection.
REQ-024 DropCount increments by 1 on each cycle with InValid=1 and InReady=0; saturates at 255; never wraps.
REQ-025 In Mode 1, a stall on a FULL target blocks input; the pointer does not skip to another channel.

Reset
REQ-026 Reset=1 asynchronously forces: Valid1..4=0, Out1..4=0, RrPtr=00, DropCount=0.
REQ-027 While Reset=1: InReady is 1 (all channels EMPTY), but no transfer is captured and no counter advances.
REQ-028 Reset asserted mid-transfer discards the in-flight word; after Reset deasserts, operation resumes on the next rising edge.

Verification
REQ-029 Mode 0, WIDTH=8: Se1=10, In=8'hA5, InValid=1 for one cycle -> next cycle Out3=8'hA5, Valid3=1; other Validk=0.
REQ-030 Mode 1, four consecutive transfers 8'h11,22,33,44 with no acks -> Out1..Out4=11,22,33,44; RrPtr back to 00; fifth offer stalls (InReady=0), DropCount=1.
REQ-031 Channel 2 FULL with 8'h01; same cycle Ack2=1, Se1=01, In=8'h02, InValid=1 -> InReady=1, next cycle Out2=8'h02, Valid2=1.
REQ-032 Ack4=1 while Valid4=0 -> no change; Ack1=Ack3=1 together while both FULL -> both Valid cleared next cycle.
REQ-033 Hold InValid=1 against a FULL target for 300 cycles -> DropCount reaches 255 and stays 255.
REQ-034 Assert Reset between clock edges with channels FULL and RrPtr=10 -> outputs cleared immediately without a clock edge; first transfer after release in Mode 1 goes to ch1.
